// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master / three-slave serial system bus.
package bus_pkg;

  localparam int DEVICE_ADDR_WIDTH = 4;
  localparam int NUM_SLAVES        = 3;
  localparam int ADDR_CNT_W        = $clog2(DEVICE_ADDR_WIDTH);

  localparam logic [DEVICE_ADDR_WIDTH-1:0] S1_ID = DEVICE_ADDR_WIDTH'(0);
  localparam logic [DEVICE_ADDR_WIDTH-1:0] S2_ID = DEVICE_ADDR_WIDTH'(1);
  localparam logic [DEVICE_ADDR_WIDTH-1:0] S3_ID = DEVICE_ADDR_WIDTH'(2);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M1   = 2'd1,
    ARB_M2   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_ADDR    = 2'd1,
    DEC_CHECK   = 2'd2,
    DEC_CONNECT = 2'd3
  } dec_state_e;

  // One-hot slave select (bit 0 = s1); all-zero marks an unmapped device address.
  function automatic logic [NUM_SLAVES-1:0] dev_decode(input logic [DEVICE_ADDR_WIDTH-1:0] dev);
    dev_decode = '0;
    case (dev)
      S1_ID:   dev_decode = 3'b001;
      S2_ID:   dev_decode = 3'b010;
      S3_ID:   dev_decode = 3'b100;
      default: dev_decode = '0;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with registered, non-preemptive grants.
// BUS_ROUND_ROBIN_EN: ties go to the master that did not own the bus last (default: m1 wins ties).
module bus_arbiter
  import bus_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       m1_breq_i,
  input  logic       m2_breq_i,
  output logic       m1_bgrant_o,
  output logic       m2_bgrant_o,
  output arb_state_e owner_o
);

  arb_state_e state_q, state_d;
  logic       tie_to_m1;

`ifdef BUS_ROUND_ROBIN_EN
  logic last_m2_q, last_m2_d;

  assign tie_to_m1 = last_m2_q;

  always_comb begin
    last_m2_d = last_m2_q;
    if (state_d == ARB_M1)      last_m2_d = 1'b0;
    else if (state_d == ARB_M2) last_m2_d = 1'b1;
  end

  // Starts as "m2 owned last" so the first tie after reset goes to m1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_m2_q <= 1'b1;
    else       last_m2_q <= last_m2_d;
  end
`else
  assign tie_to_m1 = 1'b1;
`endif

  // NOTE: defaults first so every path assigns state_d; otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (m1_breq_i && m2_breq_i) state_d = tie_to_m1 ? ARB_M1 : ARB_M2;
        else if (m1_breq_i)         state_d = ARB_M1;
        else if (m2_breq_i)         state_d = ARB_M2;
      end
      ARB_M1:  if (!m1_breq_i) state_d = ARB_IDLE;
      ARB_M2:  if (!m2_breq_i) state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: non-blocking assignment for flops so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  assign m1_bgrant_o = (state_q == ARB_M1);
  assign m2_bgrant_o = (state_q == ARB_M2);
  assign owner_o     = state_q;

endmodule

// File: rtl/sys_bus_2m3s.sv
// Serial system bus: arbitrates two masters, decodes a serial device address and routes 1-bit lanes.
// Build option BUS_ROUND_ROBIN_EN selects round-robin tie-breaking in the arbiter.
module sys_bus_2m3s
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic m1_breq,
  output logic m1_bgrant,
  input  logic m1_wdata,
  input  logic m1_mode,
  input  logic m1_mvalid,
  output logic m1_ack,
  output logic m1_rdata,
  output logic m1_svalid,
  input  logic m2_breq,
  output logic m2_bgrant,
  input  logic m2_wdata,
  input  logic m2_mode,
  input  logic m2_mvalid,
  output logic m2_ack,
  output logic m2_rdata,
  output logic m2_svalid,
  output logic s1_wdata,
  output logic s1_mode,
  output logic s1_mvalid,
  input  logic s1_rdata,
  input  logic s1_svalid,
  input  logic s1_ready,
  output logic s2_wdata,
  output logic s2_mode,
  output logic s2_mvalid,
  input  logic s2_rdata,
  input  logic s2_svalid,
  input  logic s2_ready,
  output logic s3_wdata,
  output logic s3_mode,
  output logic s3_mvalid,
  input  logic s3_rdata,
  input  logic s3_svalid,
  input  logic s3_ready
);

  localparam logic [ADDR_CNT_W-1:0] LAST_BIT = ADDR_CNT_W'(DEVICE_ADDR_WIDTH - 1);

  // The decoder logic is built for the package's device-address width only.
  if ((ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH) != DEVICE_ADDR_WIDTH || DATA_WIDTH < 1) begin : g_cfg_err
    $error("sys_bus_2m3s: unsupported ADDR_WIDTH/SLAVE_MEM_ADDR_WIDTH/DATA_WIDTH combination");
  end

  arb_state_e owner;

  bus_arbiter u_arbiter (
    .clk        (clk),
    .rstn       (rstn),
    .m1_breq_i  (m1_breq),
    .m2_breq_i  (m2_breq),
    .m1_bgrant_o(m1_bgrant),
    .m2_bgrant_o(m2_bgrant),
    .owner_o    (owner)
  );

  logic own_breq, own_wdata, own_mode, own_mvalid;

  always_comb begin
    own_breq   = 1'b0;
    own_wdata  = 1'b0;
    own_mode   = 1'b0;
    own_mvalid = 1'b0;
    case (owner)
      ARB_M1: begin
        own_breq   = m1_breq;
        own_wdata  = m1_wdata;
        own_mode   = m1_mode;
        own_mvalid = m1_mvalid;
      end
      ARB_M2: begin
        own_breq   = m2_breq;
        own_wdata  = m2_wdata;
        own_mode   = m2_mode;
        own_mvalid = m2_mvalid;
      end
      default: ;
    endcase
  end

  dec_state_e                    dec_q, dec_d;
  logic [DEVICE_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]         sel, s_ready, s_rdata, s_svalid;
  logic                          addr_ok, sel_ready;

  assign s_ready   = {s3_ready, s2_ready, s1_ready};
  assign s_rdata   = {s3_rdata, s2_rdata, s1_rdata};
  assign s_svalid  = {s3_svalid, s2_svalid, s1_svalid};
  assign sel       = dev_decode(addr_q);
  assign addr_ok   = |sel;
  assign sel_ready = |(sel & s_ready);

  // The first address bit may arrive in the same cycle the grant appears, so IDLE captures too.
  always_comb begin
    dec_d  = dec_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (!own_breq) begin
      dec_d  = DEC_IDLE;
      addr_d = '0;
      cnt_d  = '0;
    end else begin
      case (dec_q)
        DEC_IDLE: begin
          dec_d = DEC_ADDR;
          cnt_d = '0;
          if (own_mvalid) begin
            addr_d = {addr_q[DEVICE_ADDR_WIDTH-2:0], own_wdata};
            cnt_d  = ADDR_CNT_W'(1);
          end
        end
        DEC_ADDR: begin
          if (own_mvalid) begin
            addr_d = {addr_q[DEVICE_ADDR_WIDTH-2:0], own_wdata};
            if (cnt_q == LAST_BIT) begin
              dec_d = DEC_CHECK;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + ADDR_CNT_W'(1);
            end
          end
        end
        DEC_CHECK:   if (addr_ok && sel_ready) dec_d = DEC_CONNECT;
        DEC_CONNECT: dec_d = DEC_CONNECT;
        default:     dec_d = DEC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dec_q  <= DEC_IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      dec_q  <= dec_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  logic                  ack, connect, rd_bit, sv_bit;
  logic [NUM_SLAVES-1:0] route;

  // Ack lasts one cycle because CHECK always advances to CONNECT on the same condition.
  assign ack     = (dec_q == DEC_CHECK) && own_breq && addr_ok && sel_ready;
  assign m1_ack  = ack && (owner == ARB_M1);
  assign m2_ack  = ack && (owner == ARB_M2);

  assign connect = (dec_q == DEC_CONNECT);
  assign route   = connect ? sel : '0;

  assign {s3_wdata,  s2_wdata,  s1_wdata}  = route & {NUM_SLAVES{own_wdata}};
  assign {s3_mode,   s2_mode,   s1_mode}   = route & {NUM_SLAVES{own_mode}};
  assign {s3_mvalid, s2_mvalid, s1_mvalid} = route & {NUM_SLAVES{own_mvalid}};

  assign rd_bit    = |(route & s_rdata);
  assign sv_bit    = |(route & s_svalid);
  assign m1_rdata  = rd_bit && (owner == ARB_M1);
  assign m1_svalid = sv_bit && (owner == ARB_M1);
  assign m2_rdata  = rd_bit && (owner == ARB_M2);
  assign m2_svalid = sv_bit && (owner == ARB_M2);

endmodule

// File: tb/tb_sys_bus_2m3s.sv
// Scoreboard bench for sys_bus_2m3s: stimulus queues expected output snapshots, a monitor compares them.
module tb_sys_bus_2m3s;

  logic clk = 1'b0;
  logic rstn;
  logic m1_breq, m1_wdata, m1_mode, m1_mvalid, m1_bgrant, m1_ack, m1_rdata, m1_svalid;
  logic m2_breq, m2_wdata, m2_mode, m2_mvalid, m2_bgrant, m2_ack, m2_rdata, m2_svalid;
  logic s1_wdata, s1_mode, s1_mvalid, s1_rdata, s1_svalid, s1_ready;
  logic s2_wdata, s2_mode, s2_mvalid, s2_rdata, s2_svalid, s2_ready;
  logic s3_wdata, s3_mode, s3_mvalid, s3_rdata, s3_svalid, s3_ready;

  typedef struct packed {
    logic       bg1, bg2, ack1, ack2, m1_rd, m1_sv, m2_rd, m2_sv;
    logic [2:0] s_wd, s_md, s_mv;
  } out_t;

  typedef struct {
    int    cyc;
    string name;
    out_t  exp;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sys_bus_2m3s dut (
    .clk(clk), .rstn(rstn),
    .m1_breq(m1_breq), .m1_bgrant(m1_bgrant), .m1_wdata(m1_wdata), .m1_mode(m1_mode),
    .m1_mvalid(m1_mvalid), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_svalid(m1_svalid),
    .m2_breq(m2_breq), .m2_bgrant(m2_bgrant), .m2_wdata(m2_wdata), .m2_mode(m2_mode),
    .m2_mvalid(m2_mvalid), .m2_ack(m2_ack), .m2_rdata(m2_rdata), .m2_svalid(m2_svalid),
    .s1_wdata(s1_wdata), .s1_mode(s1_mode), .s1_mvalid(s1_mvalid),
    .s1_rdata(s1_rdata), .s1_svalid(s1_svalid), .s1_ready(s1_ready),
    .s2_wdata(s2_wdata), .s2_mode(s2_mode), .s2_mvalid(s2_mvalid),
    .s2_rdata(s2_rdata), .s2_svalid(s2_svalid), .s2_ready(s2_ready),
    .s3_wdata(s3_wdata), .s3_mode(s3_mode), .s3_mvalid(s3_mvalid),
    .s3_rdata(s3_rdata), .s3_svalid(s3_svalid), .s3_ready(s3_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge and retires every expectation queued for this cycle.
  always @(negedge clk) begin
    out_t a;
    exp_t e;
    a.bg1  = m1_bgrant; a.bg2  = m2_bgrant;
    a.ack1 = m1_ack;    a.ack2 = m2_ack;
    a.m1_rd = m1_rdata; a.m1_sv = m1_svalid;
    a.m2_rd = m2_rdata; a.m2_sv = m2_svalid;
    a.s_wd = {s3_wdata,  s2_wdata,  s1_wdata};
    a.s_md = {s3_mode,   s2_mode,   s1_mode};
    a.s_mv = {s3_mvalid, s2_mvalid, s1_mvalid};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.cyc);
      end else begin
        check(e.name, a, e.exp);
      end
    end
  end

  task automatic tick(input string name, input out_t e);
    exp_t x;
    x.cyc  = cyc;
    x.name = name;
    x.exp  = e;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  function automatic out_t gnt(input int k);
    gnt = '0;
    if (k == 1) gnt.bg1 = 1'b1;
    else if (k == 2) gnt.bg2 = 1'b1;
  endfunction

  task automatic set_m(input int k, input logic breq, input logic wd, input logic md, input logic mv);
    if (k == 1) begin
      m1_breq = breq; m1_wdata = wd; m1_mode = md; m1_mvalid = mv;
    end else begin
      m2_breq = breq; m2_wdata = wd; m2_mode = md; m2_mvalid = mv;
    end
  endtask

  task automatic shift_addr(input int k, input logic [3:0] a);
    for (int i = 3; i >= 0; i--) begin
      set_m(k, 1'b1, a[i], 1'b0, 1'b1);
      tick($sformatf("m%0d_addr_bit%0d", k, i), gnt(k));
    end
    set_m(k, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t e;
    rstn = 1'b0;
    set_m(1, 0, 0, 0, 0);
    set_m(2, 0, 0, 0, 0);
    {s1_rdata, s1_svalid, s2_rdata, s2_svalid, s3_rdata, s3_svalid} = '0;
    {s1_ready, s2_ready, s3_ready} = 3'b111;
    @(posedge clk); #1;
    tick("reset", '0);
    rstn = 1'b1;
    tick("post_reset", '0);

    // Simultaneous requests: m1 first, m2 after one idle cycle.
    m1_breq = 1'b1; m2_breq = 1'b1;
    tick("tie_no_grant_yet", '0);
    m1_breq = 1'b0;
    tick("tie_grant_m1", gnt(1));
    tick("handoff_idle", '0);
    tick("handoff_grant_m2", gnt(2));
    m2_breq = 1'b0;
    tick("m2_release", gnt(2));
    tick("m2_idle", '0);

    // m1 write to s3 (device 0010), then read-back and leak checks.
    set_m(1, 1, 0, 0, 0);
    tick("s3_req", '0);
    shift_addr(1, 4'b0010);
    e = gnt(1); e.ack1 = 1'b1;
    tick("s3_ack", e);
    set_m(1, 1, 1, 1, 1);
    e = gnt(1); e.s_wd = 3'b100; e.s_md = 3'b100; e.s_mv = 3'b100;
    tick("s3_write_one", e);
    set_m(1, 1, 0, 1, 1);
    s3_rdata = 1'b1; s3_svalid = 1'b1;
    e = gnt(1); e.s_md = 3'b100; e.s_mv = 3'b100; e.m1_rd = 1'b1; e.m1_sv = 1'b1;
    tick("s3_read", e);
    s3_rdata = 1'b0; s3_svalid = 1'b0; s1_rdata = 1'b1; s1_svalid = 1'b1;
    set_m(1, 1, 0, 0, 0);
    tick("s1_no_leak", gnt(1));
    s1_rdata = 1'b0; s1_svalid = 1'b0;
    set_m(1, 0, 0, 0, 0);
    tick("s3_release", gnt(1));
    tick("s3_idle", '0);

    // Unmapped device 0011: no ack, no slave traffic until release.
    set_m(1, 1, 0, 0, 0);
    tick("bad_req", '0);
    shift_addr(1, 4'b0011);
    set_m(1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) tick($sformatf("bad_no_ack%0d", i), gnt(1));
    set_m(1, 0, 0, 0, 0);
    tick("bad_release", gnt(1));
    set_m(1, 1, 0, 0, 0);
    tick("retry_req", '0);
    shift_addr(1, 4'b0000);
    e = gnt(1); e.ack1 = 1'b1;
    tick("s1_ack", e);

    // Read through s1 is combinational back to m1 only.
    s1_rdata = 1'b1; s1_svalid = 1'b1;
    set_m(1, 1, 0, 0, 1);
    e = gnt(1); e.s_mv = 3'b001; e.m1_rd = 1'b1; e.m1_sv = 1'b1;
    tick("s1_read_one", e);
    s1_rdata = 1'b0;
    e.m1_rd = 1'b0;
    tick("s1_read_zero", e);
    s1_svalid = 1'b0;
    set_m(1, 0, 0, 0, 0);
    tick("s1_release", gnt(1));
    tick("s1_idle", '0);

    // m2 to s2 (0001) while s2 is busy for five cycles.
    s2_ready = 1'b0;
    set_m(2, 1, 0, 0, 0);
    tick("s2_req", '0);
    shift_addr(2, 4'b0001);
    for (int i = 0; i < 5; i++) tick($sformatf("s2_busy%0d", i), gnt(2));
    s2_ready = 1'b1;
    e = gnt(2); e.ack2 = 1'b1;
    tick("s2_ack", e);
    set_m(2, 1, 1, 0, 1);
    s2_rdata = 1'b1; s2_svalid = 1'b1;
    e = gnt(2); e.s_wd = 3'b010; e.s_mv = 3'b010; e.m2_rd = 1'b1; e.m2_sv = 1'b1;
    tick("s2_connect", e);
    s2_rdata = 1'b0; s2_svalid = 1'b0;
    set_m(2, 0, 0, 0, 0);
    tick("s2_release", gnt(2));
    tick("s2_idle", '0);

    // Reset asserted mid-cycle while a path is open.
    set_m(1, 1, 0, 0, 0);
    tick("rst_req", '0);
    shift_addr(1, 4'b0000);
    e = gnt(1); e.ack1 = 1'b1;
    tick("rst_ack", e);
    set_m(1, 1, 1, 1, 1);
    s1_rdata = 1'b1; s1_svalid = 1'b1;
    e = gnt(1); e.s_wd = 3'b001; e.s_md = 3'b001; e.s_mv = 3'b001; e.m1_rd = 1'b1; e.m1_sv = 1'b1;
    tick("rst_connect", e);
    rstn = 1'b0;
    tick("rst_mid_connect", '0);
    set_m(1, 0, 0, 0, 0);
    s1_rdata = 1'b0; s1_svalid = 1'b0;
    tick("rst_hold", '0);
    rstn = 1'b1;
    tick("rst_released", '0);

    // Tie immediately after an m1 ownership.
    m1_breq = 1'b1;
    tick("tie2_m1_req", '0);
    m1_breq = 1'b0;
    tick("tie2_m1_grant", gnt(1));
    m1_breq = 1'b1; m2_breq = 1'b1;
    tick("tie2_idle", '0);
    m1_breq = 1'b0; m2_breq = 1'b0;
`ifdef BUS_ROUND_ROBIN_EN
    tick("tie2_round_robin_m2", gnt(2));
`else
    tick("tie2_fixed_m1", gnt(1));
`endif
    tick("tie2_idle_end", '0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
